layer_sequencer: RTL and testbench

- Sequences one dense layer on the NU_COUNT-lane MAC datapath, replacing hand-written instruction streams for plain fully-connected layers.
- Streams x from xy_mem and weights from the w_mem bank into the MAC lanes, one pass per group of up to NU_COUNT outputs.
- After each pass, drains the accumulators through the serializer and activation function and writes the results back to xy_mem.
- Sits beside the instruction controller; the top-level muxes control signals by `busy`.

---
 rtl/layer_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Dense-layer sequencer: issues x/w reads per pass of up to NU_COUNT outputs, then drains MAC -> serializer -> activation -> xy_mem.
// Per pass n_in+READ_LAT+2+L+ACT_LAT cycles; done one cycle after last write; no backpressure, start ignored while busy.
module layer_sequencer #(
  parameter int NU_COUNT     = 4,
  parameter int XY_MEM_DEPTH = 8,
  parameter int W_MEM_DEPTH  = 10,
  parameter int DIM_W        = 8,
  parameter int READ_LAT     = 1,
  parameter int ACT_LAT      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIM_W-1:0]        cfg_n_in,
  input  logic [DIM_W-1:0]        cfg_n_out,
  input  logic [XY_MEM_DEPTH-1:0] cfg_x_base,
  input  logic [W_MEM_DEPTH-1:0]  cfg_w_base,
  input  logic [XY_MEM_DEPTH-1:0] cfg_y_base,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [XY_MEM_DEPTH-1:0] xy_read_addr,
  output logic [W_MEM_DEPTH-1:0]  w_read_addr,
  output logic [NU_COUNT-1:0]     mac_reg_enable,
  output logic                    mac_acc_loopback,
  output logic                    mac_acc_update,
  output logic                    serializer_update,
  output logic                    act_input_select,
  output logic                    xy_write_enable,
  output logic [XY_MEM_DEPTH-1:0] xy_write_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_UPDATE, S_LOAD, S_SERIAL, S_FLUSH, S_FIN
  } state_t;

  localparam int LAT_MAX = (READ_LAT > ACT_LAT) ? READ_LAT : ACT_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX + 1) : 1;
  localparam logic [DIM_W-1:0]        D_ONE  = 1;
  localparam logic [DIM_W-1:0]        D_NU   = DIM_W'(NU_COUNT);
  localparam logic [XY_MEM_DEPTH-1:0] XY_ONE = 1;
  localparam logic [W_MEM_DEPTH-1:0]  W_ONE  = 1;

  state_t                  r_state;
  logic                    r_busy, r_done, r_err;
  logic [DIM_W-1:0]        r_n_in, r_rem, r_k;
  logic [CNT_W-1:0]        r_cnt;
  logic [XY_MEM_DEPTH-1:0] r_x_base, r_y_ptr, r_xy_raddr, r_wr_addr;
  logic [W_MEM_DEPTH-1:0]  r_w_ptr, r_w_raddr;
  logic [NU_COUNT-1:0]     r_iss_en;
  logic                    r_iss_lb, r_upd, r_sload, r_act, r_wr_vld;

  logic [DIM_W-1:0] w_len, w_rem_next;
  logic             w_ser_last, w_pass_end, w_last_pass;

  function automatic logic [NU_COUNT-1:0] lanes(input logic [DIM_W-1:0] rem);
    logic [NU_COUNT-1:0] v;
    v = '0;
    for (int i = 0; i < NU_COUNT; i++) v[i] = (DIM_W'(i) < rem);
    return v;
  endfunction

  assign w_len       = (r_rem > D_NU) ? D_NU : r_rem;
  assign w_rem_next  = r_rem - D_NU;
  assign w_last_pass = (r_rem <= D_NU);
  assign w_ser_last  = (r_k == w_len - D_ONE);
  // With ACT_LAT=0 the pass ends on the last serial cycle, FLUSH is skipped.
  assign w_pass_end  = (r_state == S_FLUSH && r_cnt == '0) ||
                       (ACT_LAT == 0 && r_state == S_SERIAL && w_ser_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_n_in     <= '0;
      r_rem      <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_x_base   <= '0;
      r_y_ptr    <= '0;
      r_xy_raddr <= '0;
      r_wr_addr  <= '0;
      r_w_ptr    <= '0;
      r_w_raddr  <= '0;
      r_iss_en   <= '0;
      r_iss_lb   <= 1'b0;
      r_upd      <= 1'b0;
      r_sload    <= 1'b0;
      r_act      <= 1'b0;
      r_wr_vld   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_busy   <= 1'b1;
          r_n_in   <= cfg_n_in;
          r_rem    <= cfg_n_out;
          r_x_base <= cfg_x_base;
          r_y_ptr  <= cfg_y_base;
          if (cfg_n_in == '0 || cfg_n_out == '0) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_state    <= S_ISSUE;
            r_k        <= '0;
            r_xy_raddr <= cfg_x_base;
            r_w_raddr  <= cfg_w_base;
            r_w_ptr    <= cfg_w_base + W_ONE;
            r_iss_en   <= lanes(cfg_n_out);
            r_iss_lb   <= 1'b0;
          end
        end
        S_ISSUE: if (r_k == r_n_in - D_ONE) begin
          r_state    <= S_DRAIN;
          r_cnt      <= CNT_W'(READ_LAT - 1);
          r_xy_raddr <= '0;
          r_w_raddr  <= '0;
          r_iss_en   <= '0;
          r_iss_lb   <= 1'b0;
        end else begin
          r_k        <= r_k + D_ONE;
          r_xy_raddr <= r_xy_raddr + XY_ONE;
          r_w_raddr  <= r_w_ptr;
          r_w_ptr    <= r_w_ptr + W_ONE;
          r_iss_lb   <= 1'b1;
        end
        S_DRAIN: if (r_cnt == '0) begin
          r_state <= S_UPDATE;
          r_upd   <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        S_UPDATE: begin
          r_state <= S_LOAD;
          r_upd   <= 1'b0;
          r_sload <= 1'b1;
        end
        S_LOAD: begin
          r_state   <= S_SERIAL;
          r_sload   <= 1'b0;
          r_act     <= 1'b1;
          r_k       <= '0;
          r_wr_vld  <= 1'b1;
          r_wr_addr <= r_y_ptr;
          r_y_ptr   <= r_y_ptr + XY_ONE;
        end
        S_SERIAL: if (w_ser_last) begin
          r_state  <= S_FLUSH;
          r_cnt    <= CNT_W'(ACT_LAT - 1);
          r_wr_vld <= 1'b0;
        end else begin
          r_k       <= r_k + D_ONE;
          r_wr_addr <= r_y_ptr;
          r_y_ptr   <= r_y_ptr + XY_ONE;
        end
        S_FLUSH: r_cnt <= r_cnt - 1'b1;
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      // End of pass takes priority over the SERIAL/FLUSH updates above.
      if (w_pass_end) begin
        r_act    <= 1'b0;
        r_wr_vld <= 1'b0;
        if (w_last_pass) begin
          r_state <= S_FIN;
          r_done  <= 1'b1;
        end else begin
          r_state    <= S_ISSUE;
          r_rem      <= w_rem_next;
          r_k        <= '0;
          r_xy_raddr <= r_x_base;
          r_w_raddr  <= r_w_ptr;
          r_w_ptr    <= r_w_ptr + W_ONE;
          r_iss_en   <= lanes(w_rem_next);
          r_iss_lb   <= 1'b0;
        end
      end
    end
  end

  // Lane enables / loopback follow the read data through memory latency.
  logic [NU_COUNT:0] r_rd_dly [READ_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LAT; i++) r_rd_dly[i] <= '0;
    end else begin
      r_rd_dly[0] <= {r_iss_lb, r_iss_en};
      for (int i = 1; i < READ_LAT; i++) r_rd_dly[i] <= r_rd_dly[i-1];
    end
  end

  generate
    if (ACT_LAT == 0) begin : g_wr_direct
      assign xy_write_enable = r_wr_vld;
      assign xy_write_addr   = r_wr_addr;
    end else begin : g_wr_delay
      logic [XY_MEM_DEPTH:0] r_wr_dly [ACT_LAT];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < ACT_LAT; i++) r_wr_dly[i] <= '0;
        end else begin
          r_wr_dly[0] <= {r_wr_vld, r_wr_addr};
          for (int i = 1; i < ACT_LAT; i++) r_wr_dly[i] <= r_wr_dly[i-1];
        end
      end
      assign xy_write_enable = r_wr_dly[ACT_LAT-1][XY_MEM_DEPTH];
      assign xy_write_addr   = r_wr_dly[ACT_LAT-1][XY_MEM_DEPTH-1:0];
    end
  endgenerate

  assign busy              = r_busy;
  assign done              = r_done;
  assign err               = r_err;
  assign xy_read_addr      = r_xy_raddr;
  assign w_read_addr       = r_w_raddr;
  assign mac_reg_enable    = r_rd_dly[READ_LAT-1][NU_COUNT-1:0];
  assign mac_acc_loopback  = r_rd_dly[READ_LAT-1][NU_COUNT];
  assign mac_acc_update    = r_upd;
  assign serializer_update = r_sload;
  assign act_input_select  = r_act;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: stimulus pushes hand-computed reads/writes/done records, a monitor pops them.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_n_in = '0, cfg_n_out = '0, cfg_x_base = '0, cfg_y_base = '0;
  logic [9:0] cfg_w_base = '0;
  logic       busy, done, err, mac_acc_loopback, mac_acc_update, serializer_update;
  logic       act_input_select, xy_write_enable;
  logic [7:0] xy_read_addr, xy_write_addr;
  logic [9:0] w_read_addr;
  logic [3:0] mac_reg_enable;

  layer_sequencer #(
    .NU_COUNT(4), .XY_MEM_DEPTH(8), .W_MEM_DEPTH(10), .DIM_W(8), .READ_LAT(1), .ACT_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out), .cfg_x_base(cfg_x_base),
    .cfg_w_base(cfg_w_base), .cfg_y_base(cfg_y_base),
    .busy(busy), .done(done), .err(err),
    .xy_read_addr(xy_read_addr), .w_read_addr(w_read_addr),
    .mac_reg_enable(mac_reg_enable), .mac_acc_loopback(mac_acc_loopback),
    .mac_acc_update(mac_acc_update), .serializer_update(serializer_update),
    .act_input_select(act_input_select), .xy_write_enable(xy_write_enable),
    .xy_write_addr(xy_write_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [9:0] w;
    logic [3:0] en;
    logic       lb;
  } rd_t;

  typedef struct packed {
    logic        err;
    logic [15:0] dly;
    logic [7:0]  passes;
  } dn_t;

  rd_t        q_rd[$];
  logic [7:0] q_wr[$];
  dn_t        q_dn[$];
  int         q_busy[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mute    = 1'b0;

  logic [37:0] all_outs;
  assign all_outs = {busy, done, err, xy_read_addr, w_read_addr, mac_reg_enable, mac_acc_loopback,
                     mac_acc_update, serializer_update, act_input_select, xy_write_enable, xy_write_addr};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen with nothing expected (got 1, required 0)", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  logic       prev_busy = 1'b0;
  logic [7:0] prev_x = '0;
  logic [9:0] prev_w = '0;
  int         acc_cyc = 0, bcnt = 0, upd_cnt = 0;
  rd_t        e_rd;
  dn_t        e_dn;

  always @(negedge clk) begin
    if (!reset || mute) begin
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        acc_cyc = cyc;
        bcnt    = 0;
        upd_cnt = 0;
      end
      if (busy) bcnt++;
      if (mac_acc_update) upd_cnt++;
      if (!busy && prev_busy) begin
        if (q_busy.size() == 0) unexpected("busy_fall");
        else check("busy_len", 64'(bcnt), 64'(q_busy.pop_front()));
      end
      if (mac_reg_enable != 4'h0) begin
        if (q_rd.size() == 0) unexpected("mac_enable");
        else begin
          e_rd = q_rd.pop_front();
          check("rd_x_addr", 64'(prev_x), 64'(e_rd.x));
          check("rd_w_addr", 64'(prev_w), 64'(e_rd.w));
          check("rd_lanes", 64'(mac_reg_enable), 64'(e_rd.en));
          check("rd_loopback", 64'(mac_acc_loopback), 64'(e_rd.lb));
        end
      end
      if (xy_write_enable) begin
        if (q_wr.size() == 0) unexpected("xy_write");
        else begin
          check("wr_addr", 64'(xy_write_addr), 64'(q_wr.pop_front()));
          check("wr_act_sel", 64'(act_input_select), 64'd1);
        end
      end
      if (done) begin
        if (q_dn.size() == 0) unexpected("done");
        else begin
          e_dn = q_dn.pop_front();
          check("done_err", 64'(err), 64'(e_dn.err));
          check("done_cycle", 64'(cyc - acc_cyc), 64'(e_dn.dly));
          check("passes", 64'(upd_cnt), 64'(e_dn.passes));
        end
      end
      if (err && !done) unexpected("err_without_done");
      prev_busy = busy;
    end
    prev_x = xy_read_addr;
    prev_w = w_read_addr;
  end

  task automatic exp_rd_run(input logic [7:0] x0, input logic [9:0] w0, input int n, input logic [3:0] en);
    for (int k = 0; k < n; k++) q_rd.push_back('{x: x0 + 8'(k), w: w0 + 10'(k), en: en, lb: (k != 0)});
  endtask

  task automatic exp_wr_run(input logic [7:0] y0, input int n);
    for (int k = 0; k < n; k++) q_wr.push_back(y0 + 8'(k));
  endtask

  task automatic exp_done(input logic e, input int dly, input int passes, input int blen);
    q_dn.push_back('{err: e, dly: 16'(dly), passes: 8'(passes)});
    q_busy.push_back(blen);
  endtask

  task automatic set_cfg(input logic [7:0] ni, input logic [7:0] no, input logic [7:0] xb,
                         input logic [9:0] wb, input logic [7:0] yb);
    cfg_n_in = ni; cfg_n_out = no; cfg_x_base = xb; cfg_w_base = wb; cfg_y_base = yb;
  endtask

  task automatic launch(input logic [7:0] ni, input logic [7:0] no, input logic [7:0] xb,
                        input logic [9:0] wb, input logic [7:0] yb);
    @(posedge clk); #1;
    set_cfg(ni, no, xb, wb, yb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_busy_rise(input string name, input int budget);
    bit seen = 1'b0;
    bit low  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!busy) low = 1'b1;
      else if (low) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: busy did not rise within %0d cycles", name, budget);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'(all_outs), 64'd0);
    reset = 1'b1;

    // Abort mid-ISSUE with reset, then rerun the same layer in full.
    mute = 1'b1;
    launch(8'd5, 8'd4, 8'd30, 10'd50, 8'd70);
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_outputs", 64'(all_outs), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    mute  = 1'b0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    exp_rd_run(8'd30, 10'd50, 5, 4'hF);
    exp_wr_run(8'd70, 4);
    exp_done(1'b0, 13, 1, 14);
    launch(8'd5, 8'd4, 8'd30, 10'd50, 8'd70);
    wait_done("rerun_5x4", 40);
    repeat (2) @(negedge clk);

    // Two passes: 4 lanes then 2 lanes.
    exp_rd_run(8'd0, 10'd0, 3, 4'hF);
    exp_rd_run(8'd0, 10'd3, 3, 4'h3);
    exp_wr_run(8'd16, 6);
    exp_done(1'b0, 20, 2, 21);
    launch(8'd3, 8'd6, 8'd0, 10'd0, 8'd16);
    wait_done("layer_3x6", 60);
    repeat (2) @(negedge clk);

    // Minimal layer.
    exp_rd_run(8'd5, 10'd7, 1, 4'h1);
    exp_wr_run(8'd9, 1);
    exp_done(1'b0, 6, 1, 7);
    launch(8'd1, 8'd1, 8'd5, 10'd7, 8'd9);
    wait_done("layer_1x1", 30);
    repeat (2) @(negedge clk);

    // Zero dimensions: error completion, no memory traffic.
    exp_done(1'b1, 0, 0, 1);
    launch(8'd3, 8'd0, 8'd1, 10'd2, 8'd3);
    wait_done("n_out_zero", 10);
    repeat (2) @(negedge clk);
    exp_done(1'b1, 0, 0, 1);
    launch(8'd0, 8'd3, 8'd1, 10'd2, 8'd3);
    wait_done("n_in_zero", 10);
    repeat (2) @(negedge clk);

    // Address wrap on x, w and y.
    q_rd.push_back('{x: 8'd254, w: 10'd1022, en: 4'h3, lb: 1'b0});
    q_rd.push_back('{x: 8'd255, w: 10'd1023, en: 4'h3, lb: 1'b1});
    q_rd.push_back('{x: 8'd0,   w: 10'd0,    en: 4'h3, lb: 1'b1});
    q_rd.push_back('{x: 8'd1,   w: 10'd1,    en: 4'h3, lb: 1'b1});
    q_wr.push_back(8'd255);
    q_wr.push_back(8'd0);
    exp_done(1'b0, 10, 1, 11);
    launch(8'd4, 8'd2, 8'd254, 10'd1022, 8'd255);
    wait_done("wrap", 30);
    repeat (2) @(negedge clk);

    // start held through a layer; cfg changed mid-layer applies only to the next accept.
    exp_rd_run(8'd10, 10'd100, 2, 4'hF);
    exp_rd_run(8'd10, 10'd102, 2, 4'h1);
    exp_wr_run(8'd40, 5);
    exp_done(1'b0, 17, 2, 18);
    exp_rd_run(8'd20, 10'd200, 1, 4'h3);
    exp_wr_run(8'd60, 2);
    exp_done(1'b0, 7, 1, 8);
    @(posedge clk); #1;
    set_cfg(8'd2, 8'd5, 8'd10, 10'd100, 8'd40);
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    set_cfg(8'd1, 8'd2, 8'd20, 10'd200, 8'd60);
    wait_done("held_first", 40);
    wait_busy_rise("held_second_accept", 10);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("held_second", 30);
    repeat (3) @(negedge clk);

    check("rd_queue_empty", 64'(q_rd.size()), 64'd0);
    check("wr_queue_empty", 64'(q_wr.size()), 64'd0);
    check("done_queue_empty", 64'(q_dn.size()), 64'd0);
    check("busy_queue_empty", 64'(q_busy.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
